// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: fixed-latency main-memory model behind the cache controller.
//
// A request (mem_MemRead / mem_MemWrite, level, held until mem_ready) is latched
// in IDLE. The controller then counts down LATENCY cycles and completes in DONE.
// Completion is signalled by a one-cycle mem_ready pulse. On the edge entering
// DONE a write commits to the array, or a read registers the addressed word into
// mem_rdata.
//
// Ports:
//   iCLK          clock, rising edge
//   iRST_n        asynchronous active-low reset (array contents are kept)
//   mem_addr      byte address; word index is mem_addr[DEPTH_W+1:2]
//   mem_wdata     write data
//   mem_MemWrite  write request (wins if mem_MemRead is also high)
//   mem_MemRead   read request
//   mem_rdata     last read result, held until the next read completes
//   mem_ready     one-cycle completion pulse
//   mem_err       error flag for the completing request
//
// Build option: define MEM_MISALIGN_CHK_EN to flag requests with
// mem_addr[1:0] != 0. Such a request completes with mem_err=1, does not write
// the array and leaves mem_rdata unchanged. Without the macro, mem_addr[1:0]
// is ignored and mem_err is tied low.
module main_mem_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned LATENCY = 4   // legal range 1..15
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_MemWrite,
  input  logic              mem_MemRead,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LatInit = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q;

  // Operation seen on the edge entering DONE: live inputs when LATENCY=1
  // (accept and complete on the same edge), latched values otherwise.
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic                op_we;
  logic                enter_done;
  logic                misalign;
  logic                arr_wr;
  logic                rd_upd;
  logic [DEPTH_W-1:0]  idx;

  logic [DATA_W-1:0]   mem_q [2**DEPTH_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    op_addr    = addr_q;
    op_wdata   = wdata_q;
    op_we      = we_q;
    enter_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_MemRead || mem_MemWrite) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          we_d     = mem_MemWrite;
          op_addr  = mem_addr;
          op_wdata = mem_wdata;
          op_we    = mem_MemWrite;
          if (LATENCY == 1) begin
            state_d    = StDone;
            cnt_d      = 4'd0;
            enter_done = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = LatInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd1) begin
          state_d    = StDone;
          cnt_d      = 4'd0;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = |op_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign idx = op_addr[DEPTH_W+1:2];
  // Gate with reset so a LATENCY=1 request seen while in reset cannot write.
  assign arr_wr = enter_done & op_we & ~misalign & iRST_n;
  assign rd_upd = enter_done & ~op_we & ~misalign;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      if (rd_upd) rdata_q <= mem_q[idx];
    end
  end

  // Storage array: no reset, contents survive iRST_n.
  always_ff @(posedge iCLK) begin
    if (arr_wr) mem_q[idx] <= op_wdata;
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == StDone);

`ifdef MEM_MISALIGN_CHK_EN
  logic err_q;
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      err_q <= 1'b0;
    end else if (enter_done) begin
      err_q <= misalign;
    end
  end
  assign mem_err = err_q & (state_q == StDone);
`else
  assign mem_err = 1'b0;
`endif

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{op_addr[ADDR_W-1:DEPTH_W+2], op_addr[1:0]};

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width.
REQ-002 Parameter DATA_W, 32, word width.
REQ-003 Parameter DEPTH_W, 10, log2 of array depth in words (1024 words).
REQ-004 Parameter LATENCY, 4, cycles from request acceptance to ready; legal range 1..15.
REQ-005 iCLK  input  1  clock, all state on rising edge.
REQ-006 iRST_n  input  1  asynchronous, active-low reset.
REQ-007 mem_addr  input  ADDR_W  byte address from cache controller.
REQ-008 mem_wdata  input  DATA_W  write data from cache controller.
REQ-009 mem_MemWrite  input  1  write request, level, held until ready.
REQ-010 mem_MemRead  input  1  read request, level, held until ready.
REQ-011 mem_rdata  output  DATA_W  read result to cache controller.
REQ-012 mem_ready  output  1  one-cycle completion pulse.
REQ-013 mem_err  output  1  error flag for the completing request.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 IDLE: request seen at an edge (MemRead|MemWrite) SHALL latch addr, wdata and op, then go to BUSY with counter=LATENCY-1; LATENCY=1 goes straight to DONE.
REQ-016 Both MemRead and MemWrite high at acceptance SHALL be treated as a write.
REQ-017 BUSY SHALL decrement the counter each cycle and go to DONE on the edge where counter==1.
REQ-018 On the edge entering DONE: a write SHALL commit latched wdata to the array; a read SHALL register array[word] into mem_rdata.
REQ-019 mem_ready SHALL be high only in DONE, for exactly one cycle; DONE SHALL always return to IDLE.
REQ-020 Latency: for a request accepted at edge E, mem_ready SHALL be high in the cycle following edge E+LATENCY-1 (LATENCY cycles after acceptance).
REQ-021 A request present in IDLE right after DONE SHALL be accepted without a gap cycle (write-back followed by allocate read).
REQ-022 Inputs changing during BUSY SHALL be ignored; only latched values are used.
REQ-023 Word index SHALL be addr[DEPTH_W+1:2]; address bits above SHALL be ignored (aliasing).
REQ-024 mem_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-025 A read completing at an address written earlier SHALL return the written data (no stale read).

Reset
REQ-026 Asserting iRST_n low SHALL force IDLE, counter=0, mem_ready=0, mem_rdata=0, mem_err=0 immediately.
REQ-027 Reset mid-BUSY SHALL abort the request; a pending write SHALL NOT commit.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MEM_MISALIGN_CHK_EN defined: a request with addr[1:0]!=0 SHALL complete with normal latency, mem_err=1 in its DONE cycle, no array write, and mem_rdata unchanged.
REQ-030 Macro MEM_MISALIGN_CHK_EN undefined: addr[1:0] SHALL be ignored and mem_err SHALL be tied 0.

Verification
REQ-031 LATENCY=4; write 0xDEADBEEF to 0x10, then read 0x10 -> ready 4 cycles after each acceptance, rdata=0xDEADBEEF.
REQ-032 Write 0x11111111 to 0x04 with ready; next cycle read 0x84 (same index, DEPTH_W=5) -> back-to-back accept, rdata=0x11111111 (aliasing).
REQ-033 LATENCY=1; read 0x0 after write of 0x5A5A5A5A -> ready in cycle after acceptance, single-cycle pulse, rdata=0x5A5A5A5A.
REQ-034 Write 0xCAFEF00D to 0x20, assert iRST_n low 2 cycles after acceptance, then read 0x20 -> ready never pulses for the write; rdata != 0xCAFEF00D (prior value kept).
REQ-035 MEM_MISALIGN_CHK_EN on; write to 0x22 -> ready with err=1, read 0x20 returns old data; macro off -> err=0 and write lands at word 0x20.
REQ-036 MemRead and MemWrite both high, addr 0x30, wdata 0x12345678 -> treated as write; subsequent read 0x30 returns 0x12345678.
